// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : PC-select codes, fetch FSM states and word constants.  Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [1:0] PC_SEL_INC  = 2'b00;
    localparam logic [1:0] PC_SEL_B    = 2'b01;
    localparam logic [1:0] PC_SEL_F    = 2'b10;
    localparam logic [1:0] PC_SEL_HOLD = 2'b11;

    localparam logic [31:0] WORD_BYTES      = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2,
        F_DONE = 2'd3
    } fetch_state_t;

    function automatic logic is_redirect(input logic write_pc, input logic [1:0] pc_s);
        return write_pc && ((pc_s == PC_SEL_B) || (pc_s == PC_SEL_F));
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_if : instruction-memory req/gnt/rvalid read bus.  Rev 1.0
// ---------------------------------------------------------------------------
interface instr_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_next_sel : combinational next-PC mux (PC+4 / BX / branch / hold).  Rev 1.0
// ---------------------------------------------------------------------------
module pc_next_sel (
    input  logic [31:0] pc,
    input  logic [31:0] b_data,
    input  logic [31:0] f_data,
    input  logic [1:0]  pc_s,
    input  logic        write_pc,
    input  logic        capture,
    output logic [31:0] next_pc
);
    import cpu_pkg::*;

    always_comb begin
        next_pc = pc;
        if (write_pc) begin
            case (pc_s)
                // Increment is tied to the fetch capture so a level-held
                // write_pc cannot advance the PC more than once per fetch.
                PC_SEL_INC: if (capture) next_pc = pc + WORD_BYTES;
                PC_SEL_B:   next_pc = b_data & WORD_ALIGN_MASK;
                PC_SEL_F:   next_pc = f_data & WORD_ALIGN_MASK;
                default:    next_pc = pc;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch : PC register, imem read handshake and IR capture.  Rev 1.0
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_ir,
    input  logic                 write_pc,
    input  logic [1:0]           pc_s,
    input  logic [31:0]          B_data,
    input  logic [31:0]          F_data,
    instr_fetch_if.master        imem,
    output logic [31:0]          IR,
    output logic                 W_IR_valid,
    output logic [31:0]          PC,
    output logic                 fetch_err
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t     state;
    fetch_state_t     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             kill;
    logic             redirect;
    logic             capture;
    logic             timeout_hit;
    logic [31:0]      pc_nxt;

    assign redirect    = is_redirect(write_pc, pc_s);
    assign capture     = (state == F_WAIT) && imem.rvalid && !kill && !redirect;
    assign timeout_hit = (state == F_WAIT) && !imem.rvalid && (cnt == CNT_LAST);

    assign imem.req  = (state == F_REQ);
    assign imem.addr = PC;

    pc_next_sel u_pc_next_sel (
        .pc       (PC),
        .b_data   (B_data),
        .f_data   (F_data),
        .pc_s     (pc_s),
        .write_pc (write_pc),
        .capture  (capture),
        .next_pc  (pc_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            F_IDLE: if (write_ir) state_nxt = F_REQ;
            F_REQ:  if (imem.gnt) state_nxt = F_WAIT;
            F_WAIT: begin
                if (imem.rvalid)      state_nxt = F_DONE;
                else if (timeout_hit) state_nxt = F_IDLE;
            end
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= F_IDLE;
            PC         <= RESET_PC;
            IR         <= 32'h0;
            W_IR_valid <= 1'b0;
            fetch_err  <= 1'b0;
            cnt        <= '0;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            PC         <= pc_nxt;
            W_IR_valid <= capture;
            if (capture)     IR        <= imem.rdata;
            if (timeout_hit) fetch_err <= 1'b1;

            if ((state == F_REQ) && imem.gnt) cnt <= '0;
            else if (state == F_WAIT)         cnt <= cnt + CNT_W'(1);

            // A redirect granted in the same cycle also leaves a stale
            // response in flight, so it is killed just like one in F_WAIT.
            if ((state == F_DONE) || timeout_hit)
                kill <= 1'b0;
            else if (redirect && ((state == F_WAIT) || ((state == F_REQ) && imem.gnt)))
                kill <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed self-checking bench for instr_fetch.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        write_ir;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic [31:0] b_data;
    logic [31:0] f_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_if imem ();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_ir   (write_ir),
        .write_pc   (write_pc),
        .pc_s       (pc_s),
        .B_data     (b_data),
        .F_data     (f_data),
        .imem       (imem.master),
        .IR         (ir),
        .W_IR_valid (ir_valid),
        .PC         (pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; write_ir = 1'b0; write_pc = 1'b0; pc_s = 2'b00;
        b_data = '0; f_data = '0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        tick(); tick();
        check("rst_pc",    pc, 32'h0);
        check("rst_ir",    ir, 32'h0);
        check("rst_valid", {31'b0, ir_valid}, 32'h0);
        check("rst_req",   {31'b0, imem.req}, 32'h0);
        check("rst_err",   {31'b0, fetch_err}, 32'h0);

        // Zero-wait fetch
        rst = 1'b1; write_ir = 1'b1; write_pc = 1'b1; pc_s = 2'b00; imem.gnt = 1'b1;
        tick();
        check("t1_req",  {31'b0, imem.req}, 32'h1);
        check("t1_addr", imem.addr, 32'h0);
        tick();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hE3A0_1005;
        check("t1_valid_early", {31'b0, ir_valid}, 32'h0);
        tick();
        check("t1_valid", {31'b0, ir_valid}, 32'h1);
        check("t1_ir",    ir, 32'hE3A0_1005);
        check("t1_pc",    pc, 32'h4);
        imem.rvalid = 1'b0; write_ir = 1'b0;
        tick();
        check("t1_valid_pulse", {31'b0, ir_valid}, 32'h0);
        check("t1_pc_hold",     pc, 32'h4);

        // Delayed grant and response
        write_ir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_req_stable",  {31'b0, imem.req}, 32'h1);
            check("t2_addr_stable", imem.addr, 32'h4);
        end
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0;
        check("t2_req_drop", {31'b0, imem.req}, 32'h0);
        tick();
        check("t2_wait_valid", {31'b0, ir_valid}, 32'h0);
        tick();
        imem.rvalid = 1'b1; imem.rdata = 32'hE59F_0010;
        tick();
        check("t2_valid", {31'b0, ir_valid}, 32'h1);
        check("t2_ir",    ir, 32'hE59F_0010);
        check("t2_pc",    pc, 32'h8);
        imem.rvalid = 1'b0; write_ir = 1'b0;
        tick();
        check("t2_valid_pulse", {31'b0, ir_valid}, 32'h0);
        check("t2_pc_hold",     pc, 32'h8);

        // BX with unaligned target
        pc_s = 2'b01; b_data = 32'h0000_1003;
        tick();
        check("t3_bx_pc", pc, 32'h0000_1000);
        pc_s = 2'b00; write_ir = 1'b1;
        tick();
        check("t3_addr", imem.addr, 32'h0000_1000);
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0;

        // Branch redirect while the response is outstanding
        pc_s = 2'b10; f_data = 32'h0000_0200;
        tick();
        check("t4_redirect_pc", pc, 32'h0000_0200);
        pc_s = 2'b00;
        tick();
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        tick();
        check("t4_killed_valid", {31'b0, ir_valid}, 32'h0);
        check("t4_killed_ir",    ir, 32'hE59F_0010);
        check("t4_killed_pc",    pc, 32'h0000_0200);
        imem.rvalid = 1'b0;
        tick();
        tick();
        check("t4_refetch_addr", imem.addr, 32'h0000_0200);
        check("t4_refetch_req",  {31'b0, imem.req}, 32'h1);
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'h1111_1111;
        tick();
        check("t4_valid", {31'b0, ir_valid}, 32'h1);
        check("t4_ir",    ir, 32'h1111_1111);
        check("t4_pc",    pc, 32'h0000_0204);
        imem.rvalid = 1'b0; write_ir = 1'b0;
        tick();

        // Response timeout
        write_ir = 1'b1;
        tick();
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0; write_ir = 1'b0;
        repeat (15) tick();
        check("t5_err_early", {31'b0, fetch_err}, 32'h0);
        tick();
        check("t5_err", {31'b0, fetch_err}, 32'h1);
        check("t5_pc",  pc, 32'h0000_0204);
        check("t5_ir",  ir, 32'h1111_1111);
        tick(); tick();
        check("t5_err_sticky", {31'b0, fetch_err}, 32'h1);
        check("t5_idle_req",   {31'b0, imem.req}, 32'h0);
        check("t5_no_valid",   {31'b0, ir_valid}, 32'h0);

        // PC wrap at the top of the address space
        pc_s = 2'b10; f_data = 32'hFFFF_FFFF;
        tick();
        check("t6_pc_top", pc, 32'hFFFF_FFFC);
        pc_s = 2'b00; write_ir = 1'b1;
        tick();
        check("t6_addr_top", imem.addr, 32'hFFFF_FFFC);
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = 32'hA5A5_A5A5;
        tick();
        check("t6_wrap_pc",    pc, 32'h0);
        check("t6_wrap_valid", {31'b0, ir_valid}, 32'h1);
        imem.rvalid = 1'b0; pc_s = 2'b01; b_data = 32'h0000_0040;
        tick();
        check("t6_bx_done", pc, 32'h0000_0040);
        pc_s = 2'b00;
        tick();
        check("t6_addr_40", imem.addr, 32'h0000_0040);
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0;

        // Asynchronous reset while waiting for the response
        #2;
        rst = 1'b0;
        #1;
        check("t7_pc",    pc, 32'h0);
        check("t7_ir",    ir, 32'h0);
        check("t7_valid", {31'b0, ir_valid}, 32'h0);
        check("t7_req",   {31'b0, imem.req}, 32'h0);
        check("t7_err",   {31'b0, fetch_err}, 32'h0);
        write_ir = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("t7_idle_req", {31'b0, imem.req}, 32'h0);
        check("t7_idle_pc",  pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
